// File: rtl/cp0_if.sv
// M-stage to coprocessor-0 bus: exception requests, mfc0/mtc0 access,
// and the fetch-redirect outputs.
interface cp0_if;
    logic [5:0]  HWInt;
    logic [31:0] PC;
    logic        BD;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] NPC_exc;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output HWInt, PC, BD, ExcValid, ExcCode, A1, A2, DIn, We, EXLClr,
        input  IntReq, NPC_exc, EPC, DOut
    );

    modport slave (
        input  HWInt, PC, BD, ExcValid, ExcCode, A1, A2, DIn, We, EXLClr,
        output IntReq, NPC_exc, EPC, DOut
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt/exception arbitration and
// the handler/eret redirect target for fetch.
module cp0 #(
    parameter logic [31:0] PRID    = 32'h0000_4D49,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic clk,
    input  logic reset,
    cp0_if.slave bus
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_pend;
    logic        int_req;
    logic [31:0] epc_next;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_pend  = (|(bus.HWInt & im)) & ie & ~exl;
    assign int_req   = (int_pend | bus.ExcValid) & ~exl;
    // Delay-slot victims resume at the branch so the branch is re-executed.
    assign epc_next  = (bus.BD ? bus.PC - 32'd4 : bus.PC) & 32'hFFFF_FFFC;
    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {cause_bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

    assign bus.IntReq  = int_req;
    assign bus.NPC_exc = int_req ? HANDLER : epc;
    assign bus.EPC     = epc;

    always_comb begin
        bus.DOut = 32'b0;
        case (bus.A1)
            5'd12:   bus.DOut = sr_val;
            5'd13:   bus.DOut = cause_val;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID;
            default: bus.DOut = 32'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                // The flushed M instruction's mtc0 is dropped here.
                exl      <= 1'b1;
                cause_bd <= bus.BD;
                exc_code <= int_pend ? 5'd0 : bus.ExcCode;
                epc      <= epc_next;
            end else if (bus.We) begin
                case (bus.A2)
                    5'd12: begin
                        im  <= bus.DIn[15:10];
                        exl <= bus.DIn[1];
                        ie  <= bus.DIn[0];
                    end
                    5'd14:   epc <= {bus.DIn[31:2], 2'b00};
                    default: ;
                endcase
            end
            // eret wins over a same-cycle SR write's EXL bit.
            if (bus.EXLClr)
                exl <= 1'b0;
        end
    end
endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the M stage and serves as the responder to the fetch stage's interrupt redirect. It samples the external hardware interrupt lines and synchronous exception requests, and decides when the pipeline must take an exception. On that decision it raises `IntReq`, which flushes the pipeline and steers fetch to the handler at `0x0000_4180`. It also holds SR/Cause/EPC/PRId for `mfc0`/`mtc0`, and supplies EPC to fetch for `eret`.

## Interface
Parameters:
- `PRID`, default `32'h0000_4D49`: constant value returned for register 15.
- `HANDLER`, default `32'h0000_4180`: exception entry address driven on `NPC_exc`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `HWInt` in 6: external interrupt lines, level-sensitive, mapped to IP[15:10].
- `PC` in 32: PC of the instruction currently in M.
- `BD` in 1: M-stage instruction is in a branch delay slot.
- `ExcValid` in 1: M-stage instruction raised a synchronous exception.
- `ExcCode` in 5: code for `ExcValid`; ignored when `ExcValid`=0.
- `A1` in 5: `mfc0` read register number.
- `A2` in 5: `mtc0` write register number.
- `DIn` in 32: `mtc0` write data.
- `We` in 1: `mtc0` write enable.
- `EXLClr` in 1: `eret` in M.
- `IntReq` out 1: take exception this cycle (flush + redirect).
- `NPC_exc` out 32: `HANDLER` when `IntReq`, else EPC (the `eret` target).
- `EPC` out 32: current EPC register.
- `DOut` out 32: `mfc0` read data.

## Operation
State fields:
- SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC: 32 bits, bits [1:0] always 0.

Request logic (combinational from current state and inputs):
- `IntPend` = |(HWInt & IM) & IE & ~EXL.
- `IntReq` = (`IntPend` | `ExcValid`) & ~EXL.

Register updates, in priority order per edge:
1. `reset`: SR, Cause, EPC all 0. `reset` overrides everything.
2. `IntReq`=1: EXL←1. Cause.BD←`BD`. Cause.ExcCode←0 if `IntPend`, else `ExcCode`; a hardware interrupt beats a synchronous exception in the same cycle. EPC←(`BD` ? `PC`−4 : `PC`) with bits [1:0] cleared. A simultaneous `We` is discarded, because the M instruction is being flushed.
3. Else `We`=1:
   - `A2`=12 writes IM, EXL, IE from `DIn`.
   - `A2`=14 writes EPC←{`DIn`[31:2],2'b0}.
   - Writes to 13, 15 and any other number are ignored.
4. `EXLClr`=1: EXL←0. This applies after step 3, so `eret` together with an `mtc0` SR write leaves EXL=0 and keeps the written IM/IE.

Every cycle, outside reset, Cause.IP←`HWInt`. The IP bits are not masked.

Read mux (`DOut`):
- 12 → SR
- 13 → Cause
- 14 → EPC
- 15 → `PRID`
- any other → 0

There is no write-to-read bypass: a same-cycle `mtc0` to the register being read returns the old value.

## Timing
- All outputs are valid within the same cycle as their inputs. `IntReq`, `NPC_exc` and `DOut` are combinational from registered state plus current inputs.
- State changes are visible from the cycle after the edge that writes them.
- After reset: `IntReq`=0, `EPC`=0, `DOut`=0 for `A1`=12/13/14, `NPC_exc`=0.
- `IntReq` is a one-cycle pulse per exception, because EXL=1 masks all further requests. Nested exceptions while EXL=1 are dropped, not queued. Interrupts remain level-sensitive, so a still-asserted `HWInt` is taken again once EXL clears.
- EPC arithmetic is 32-bit modular: `PC`=0 with `BD`=1 gives EPC=`32'hFFFF_FFFC`.
- Reset mid-handler (EXL=1) clears EXL; the bench must see `IntReq`=0 until IE is rewritten.

## Test plan
- **Interrupt taken:** reset; `mtc0` SR←`32'h0000_0401` (IM[10], IE); next cycle `HWInt`=6'b000001, `PC`=`32'h0000_3010`, `BD`=0 → `IntReq`=1 and `NPC_exc`=`32'h4180`. The following cycle gives EPC=`32'h3010`, SR=`32'h0403`, Cause ExcCode=0 and IP[10]=1, and `IntReq`=0 while `HWInt` stays high.
- **Delay-slot exception:** IE=0, `ExcValid`=1, `ExcCode`=5'd12, `PC`=`32'h3024`, `BD`=1 → `IntReq`=1. Next cycle EPC=`32'h3020`, Cause=`32'h8000_0030`.
- **Simultaneous interrupt and exception:** enabled interrupt with `ExcValid`=1 and `ExcCode`=10 in the same cycle → ExcCode=0. A same-cycle `We` to EPC with `32'h1234` is discarded.
- **`eret` with pending interrupt:** from EXL=1 with `HWInt` held enabled, assert `EXLClr` → `IntReq`=0 in that cycle and `NPC_exc`=EPC; the next cycle `IntReq`=1.
- **mtc0/mfc0:** `mtc0` 14←`32'h0000_3007` → read 14 gives `32'h3004`. A same-cycle read of 14 returns the old value. Read 15 gives `PRID`; read 7 gives 0.
- **Reset mid-handler:** EXL=1 and EPC≠0, assert `reset` with `HWInt`=6'h3F → all registers 0 and `IntReq`=0 on the next cycle.
